// File: rtl/scratch_ctrl.sv
// Port arbiter/sequencer for the BPF scratch register file: CPU has priority, host is starvation-bounded,
// clear sweep zeroes every entry. Optional counters under SCRATCH_CTRL_STATS_EN.
module scratch_ctrl #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int HOST_MAX_WAIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_ack,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0] rf_idata,
    output logic                  rf_wr_en,
`ifdef SCRATCH_CTRL_STATS_EN
    output logic [31:0]           stat_cpu_stalls,
    output logic [15:0]           stat_host_forced,
`endif
    input  logic [DATA_WIDTH-1:0] rf_odata
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int WAIT_W = (HOST_MAX_WAIT > 0) ? $clog2(HOST_MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0]     WAIT_MAX = WAIT_W'(HOST_MAX_WAIT);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_ptr;
    logic [WAIT_W-1:0]       wait_cnt;
    logic                    in_idle;
    logic                    host_pend;
    logic                    force_gnt;
    logic                    host_gnt;
    logic                    rf_we_arb;

    assign in_idle   = (state == S_IDLE);
    assign host_pend = host_req & ~host_ack;
    // A starved host wins even over the CPU; HOST_MAX_WAIT=0 disables forcing.
    assign force_gnt = (HOST_MAX_WAIT != 0) & in_idle & host_pend & (wait_cnt == WAIT_MAX);
    assign host_gnt  = in_idle & (force_gnt | (~cpu_req & host_pend));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == S_IDLE) begin
            if (clr_start) begin
                state_nxt = S_CLEAR;
            end
        end else begin
            if (!clr_start && (clr_ptr == PTR_LAST)) begin
                state_nxt = S_IDLE;
            end
        end
    end

    always_comb begin
        rf_addr   = '0;
        rf_idata  = '0;
        rf_we_arb = 1'b0;
        cpu_stall = 1'b0;
        clr_busy  = 1'b0;
        if (state == S_CLEAR) begin
            rf_addr   = clr_ptr;
            rf_we_arb = 1'b1;
            cpu_stall = cpu_req;
            clr_busy  = 1'b1;
        end else if (force_gnt) begin
            rf_addr   = host_addr;
            rf_idata  = host_wdata;
            rf_we_arb = host_we;
            cpu_stall = cpu_req;
        end else if (cpu_req) begin
            rf_addr   = cpu_addr;
            rf_idata  = cpu_wdata;
            rf_we_arb = cpu_we;
        end else if (host_pend) begin
            rf_addr   = host_addr;
            rf_idata  = host_wdata;
            rf_we_arb = host_we;
        end
    end

    // Keep the register file from being written while reset is held.
    assign rf_wr_en  = rf_we_arb & rst_n;
    assign cpu_rdata = rf_odata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_ptr  <= '0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= (state == S_CLEAR) & ~clr_start & (clr_ptr == PTR_LAST);
            if (clr_start) begin
                clr_ptr <= '0;
            end else if (state == S_CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_ack   <= 1'b0;
            host_rdata <= '0;
        end else begin
            host_ack <= host_gnt;
            if (host_gnt) begin
                host_rdata <= rf_odata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (host_gnt) begin
            wait_cnt <= '0;
        end else if (state == S_CLEAR) begin
            wait_cnt <= wait_cnt;
        end else if (!host_req) begin
            wait_cnt <= '0;
        end else if (host_pend && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

`ifdef SCRATCH_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cpu_stalls  <= '0;
            stat_host_forced <= '0;
        end else if (clr_start) begin
            stat_cpu_stalls  <= '0;
            stat_host_forced <= '0;
        end else begin
            if (cpu_stall && (stat_cpu_stalls != '1)) begin
                stat_cpu_stalls <= stat_cpu_stalls + 1'b1;
            end
            if (force_gnt && (stat_host_forced != '1)) begin
                stat_host_forced <= stat_host_forced + 1'b1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_scratch_ctrl.sv
// Bench for scratch_ctrl: CPU vector table, host scoreboard, forced grant, clear sweep, restart and reset corners.
module tb_scratch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [3:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        host_req, host_we;
    logic [3:0]  host_addr;
    logic [31:0] host_wdata, host_rdata;
    logic        host_ack;
    logic        clr_start, clr_busy, clr_done;
    logic [3:0]  rf_addr;
    logic [31:0] rf_idata, rf_odata;
    logic        rf_wr_en;

    logic [31:0] mem [16];
    logic [31:0] sb_q [$];

    int n_vec = 0;
    int n_err = 0;

    scratch_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_ack(host_ack),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .rf_addr(rf_addr), .rf_idata(rf_idata), .rf_wr_en(rf_wr_en), .rf_odata(rf_odata)
    );

    // Register file: synchronous write, asynchronous read.
    always @(posedge clk) if (rf_wr_en) mem[rf_addr] <= rf_idata;
    assign rf_odata = mem[rf_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [3:0] a, input logic [31:0] d);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        step();
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic cpu_rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        @(negedge clk);
        chk(nm, cpu_rdata, exp);
        step();
        cpu_req = 1'b0;
    endtask

    // Expected read data enters the scoreboard when the request is driven, leaves on host_ack.
    task automatic host_txn(input logic we, input logic [3:0] a, input logic [31:0] d,
                            input logic [31:0] exp, output int lat);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        sb_q.push_back(exp);
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (host_ack) begin
                lat = c;
                chk("host_rdata", host_rdata, sb_q.pop_front());
                break;
            end
            step();
        end
        if (lat < 0) begin
            n_vec++; n_err++;
            $display("FAIL host_timeout: got no ack expected ack within 40 cycles");
            sb_q.delete();
        end
        step();
        host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic fill_all(input logic [31:0] d);
        for (int i = 0; i < 16; i++) cpu_wr(4'(i), d);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } cvec_t;

    cvec_t tbl [10];

    initial begin
        int lat, nb, fb, ns, nd, dc, st_c, n_st, ack_c;

        tbl[0] = '{1'b1, 4'd3,  32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 4'd3,  32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 4'd0,  32'h00000011, 32'h0};
        tbl[3] = '{1'b1, 4'd15, 32'hA5A5A5A5, 32'h0};
        tbl[4] = '{1'b1, 4'd5,  32'h00000000, 32'h0};
        tbl[5] = '{1'b1, 4'd7,  32'h0BADF00D, 32'h0};
        tbl[6] = '{1'b0, 4'd15, 32'h0,        32'hA5A5A5A5};
        tbl[7] = '{1'b0, 4'd0,  32'h0,        32'h00000011};
        tbl[8] = '{1'b0, 4'd7,  32'h0,        32'h0BADF00D};
        tbl[9] = '{1'b0, 4'd3,  32'h0,        32'hDEADBEEF};

        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd1; cpu_wdata = 32'h1;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        clr_start = 1'b0;

        // Reset state, with a CPU write attempted during reset.
        #12;
        chk("rst_host_ack", 32'(host_ack), 32'd0);
        chk("rst_host_rdata", host_rdata, 32'd0);
        chk("rst_clr_busy", 32'(clr_busy), 32'd0);
        chk("rst_clr_done", 32'(clr_done), 32'd0);
        chk("rst_rf_wr_en", 32'(rf_wr_en), 32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        step();
        rst_n = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0;

        // CPU vector table: one access per cycle, never stalled.
        for (int i = 0; i < 10; i++) begin
            cpu_req = 1'b1; cpu_we = tbl[i].we; cpu_addr = tbl[i].addr; cpu_wdata = tbl[i].wdata;
            @(negedge clk);
            chk("cpu_stall", 32'(cpu_stall), 32'd0);
            chk("rf_wr_en", 32'(rf_wr_en), 32'(tbl[i].we));
            if (!tbl[i].we) chk("cpu_rdata", cpu_rdata, tbl[i].exp_rdata);
            step();
        end
        cpu_req = 1'b0; cpu_we = 1'b0;

        // Host write then read back of addr 5, CPU idle.
        host_txn(1'b1, 4'd5, 32'h12345678, 32'h00000000, lat);
        chk("host_wr_latency", 32'(lat), 32'd1);
        host_txn(1'b0, 4'd5, 32'h0, 32'h12345678, lat);
        chk("host_rd_latency", 32'(lat), 32'd1);

        // Forced host grant while the CPU requests every cycle.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 4'd7;
        sb_q.push_back(32'h0BADF00D);
        st_c = -1; n_st = 0; ack_c = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (cpu_stall) begin n_st++; st_c = c; end
            if (host_ack) begin
                ack_c = c;
                chk("forced_rdata", host_rdata, sb_q.pop_front());
                break;
            end
            step();
        end
        step();
        host_req = 1'b0; cpu_req = 1'b0;
        sb_q.delete();
        chk("forced_stall_cycle", 32'(st_c), 32'd8);
        chk("forced_stall_count", 32'(n_st), 32'd1);
        chk("forced_ack_cycle", 32'(ack_c), 32'd9);

        // Full clear sweep with the CPU requesting throughout.
        fill_all(32'hFFFFFFFF);
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd2;
        nb = 0; fb = -1; ns = 0; nd = 0; dc = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (clr_busy) begin nb++; if (fb < 0) fb = c; end
            if (cpu_stall) ns++;
            if (clr_done) begin nd++; dc = c; end
            step();
        end
        cpu_req = 1'b0;
        chk("clr_busy_cycles", 32'(nb), 32'd16);
        chk("clr_busy_first", 32'(fb), 32'd1);
        chk("clr_stall_cycles", 32'(ns), 32'd16);
        chk("clr_done_count", 32'(nd), 32'd1);
        chk("clr_done_cycle", 32'(dc), 32'd17);
        for (int i = 0; i < 16; i++) cpu_rd(4'(i), 32'h0, "clr_entry");

        // Restart at clr_ptr=9: clr_done lands 16 edges after the edge sampling the second pulse.
        clr_start = 1'b1;
        step();
        nb = 0; nd = 0; dc = -1;
        for (int c = 1; c <= 32; c++) begin
            clr_start = (c == 10);
            @(negedge clk);
            if (c == 10) chk("restart_ptr", 32'(rf_addr), 32'd9);
            if (clr_busy) nb++;
            if (clr_done) begin nd++; dc = c; end
            step();
        end
        clr_start = 1'b0;
        chk("restart_busy_cycles", 32'(nb), 32'd26);
        chk("restart_done_count", 32'(nd), 32'd1);
        chk("restart_done_cycle", 32'(dc), 32'd27);

        // Reset while the sweep sits at clr_ptr=4.
        fill_all(32'hFFFFFFFF);
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        for (int c = 1; c < 5; c++) step();
        chk("rstmid_ptr", 32'(rf_addr), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("rstmid_clr_busy", 32'(clr_busy), 32'd0);
        chk("rstmid_host_ack", 32'(host_ack), 32'd0);
        chk("rstmid_rf_wr_en", 32'(rf_wr_en), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (clr_done) nd++;
            step();
        end
        chk("rstmid_no_done", 32'(nd), 32'd0);
        for (int i = 0; i < 16; i++)
            cpu_rd(4'(i), (i < 4) ? 32'h0 : 32'hFFFFFFFF, "rstmid_entry");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
